// File: rtl/float_to_int_pkg.sv
// float_to_int shared types and constants.
// Holds the converter FSM state enum and IEEE-754 field limits.
package float_to_int_pkg;

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SPECIAL,
    CONVERT,
    PUT_Z
  } state_e;

  localparam int          EXP_BIAS    = 127;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;
  localparam logic [31:0] INT_MAX     = 32'h7FFF_FFFF;
  localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
  localparam logic [7:0]  EXP_ONE     = 8'(EXP_BIAS);
  localparam logic [7:0]  EXP_TOP     = 8'(EXP_BIAS + 30);
  localparam logic [31:0] NEG_2_31    = 32'hCF00_0000;

endpackage

// File: rtl/float_classify.sv
// float_classify: combinational operand classification.
// Flags the float cases that bypass the shift-convert loop.
module float_classify
  import float_to_int_pkg::*;
(
  input  logic [31:0] a,
  output logic        is_zero_denorm,
  output logic        is_inf_nan,
  output logic        is_nan,
  output logic        is_small,
  output logic        is_overflow
);

  logic [7:0] exp_f;

  assign exp_f = a[30:23];

  // exponent range decode; unbiased exp > 30 cannot fit in int32
  assign is_zero_denorm = (exp_f == 8'd0);
  assign is_inf_nan     = (exp_f == EXP_SPECIAL);
  assign is_nan         = is_inf_nan && (|a[22:0]);
  assign is_small       = !is_zero_denorm && (exp_f < EXP_ONE);
  assign is_overflow    = !is_inf_nan && (exp_f > EXP_TOP);

endmodule

// File: rtl/float_to_int.sv
// float_to_int: IEEE-754 single to int32, truncating toward zero.
// Build macro FLOAT_TO_INT_SATURATE_EN selects saturating overflow.
module float_to_int
  import float_to_int_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        a_m_q, a_m_d;
  logic signed [9:0]  a_e_q, a_e_d;
  logic               a_s_q, a_s_d;
  logic [31:0]        z_q, z_d;
  logic               ack_q, ack_d;
  logic               stb_q, stb_d;

  logic               is_zero_denorm;
  logic               is_inf_nan;
  logic               is_nan;
  logic               is_small;
  logic               is_overflow;
  logic [31:0]        ovf_val;

  float_classify u_classify (
    .a              (a_q),
    .is_zero_denorm (is_zero_denorm),
    .is_inf_nan     (is_inf_nan),
    .is_nan         (is_nan),
    .is_small       (is_small),
    .is_overflow    (is_overflow)
  );

`ifdef FLOAT_TO_INT_SATURATE_EN
  assign ovf_val = is_nan ? 32'd0
                 : (a_q[31] ? INT_MIN : INT_MAX);
`else
  logic nan_unused;
  assign nan_unused = is_nan;
  assign ovf_val    = INT_MIN;
`endif

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = z_q;

  // next-state and datapath for the handshake/convert FSM
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    a_m_d   = a_m_q;
    a_e_d   = a_e_q;
    a_s_d   = a_s_q;
    z_d     = z_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    unique case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        a_m_d   = {1'b1, a_q[22:0], 8'b0};
        a_e_d   = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        a_s_d   = a_q[31];
        state_d = SPECIAL;
      end
      SPECIAL: begin
        state_d = PUT_Z;
        if (a_q == NEG_2_31) begin
          z_d = INT_MIN;
        end else if (is_zero_denorm) begin
          z_d = 32'd0;
        end else if (is_inf_nan) begin
          z_d = ovf_val;
        end else if (is_overflow) begin
          z_d = ovf_val;
        end else if (is_small) begin
          z_d = 32'd0;
        end else begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (a_e_q < 10'sd31) begin
          a_m_d = a_m_q >> 1;
          a_e_d = a_e_q + 10'sd1;
        end else begin
          z_d     = a_s_q ? (32'd0 - a_m_q) : a_m_q;
          state_d = PUT_Z;
        end
      end
      PUT_Z: begin
        stb_d = 1'b1;
        if (stb_q && output_z_ack) begin
          stb_d   = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      a_m_q   <= '0;
      a_e_q   <= '0;
      a_s_q   <= 1'b0;
      z_q     <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      a_m_q   <= a_m_d;
      a_e_q   <= a_e_d;
      a_s_q   <= a_s_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int.
// Random and directed operands against an arithmetic reference model.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int total = 0;
  int bad = 0;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ovf_of(input logic [31:0] f);
`ifdef FLOAT_TO_INT_SATURATE_EN
    if (f[30:23] == 8'hFF && f[22:0] != 0) return 32'd0;
    return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    return 32'h8000_0000;
`endif
  endfunction

  function automatic logic [31:0] ref_conv(input logic [31:0] f);
    int     e;
    longint mag;
    if (f[30:23] == 8'd0) return 32'd0;
    if (f[30:23] == 8'hFF) return ovf_of(f);
    e = int'(f[30:23]) - 127;
    if (e < 0) return 32'd0;
    if (e > 32) return ovf_of(f);
    mag = longint'({1'b1, f[22:0]});
    if (e >= 23) mag = mag << (e - 23);
    else mag = mag >> (23 - e);
    if (f[31]) begin
      if (mag > 64'sd2147483648) return ovf_of(f);
      return 32'(-mag);
    end
    if (mag > 64'sd2147483647) return ovf_of(f);
    return 32'(mag);
  endfunction

  function automatic int ref_lat(input logic [31:0] f);
    int e;
    e = int'(f[30:23]) - 127;
    if (f[30:23] == 8'd0 || f[30:23] == 8'hFF) return 3;
    if (e < 0 || e > 30) return 3;
    return 35 - e;
  endfunction

  task automatic send(input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    input_a = a;
    input_a_stb = 1'b1;
    while (!input_a_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!input_a_ack) begin
      total++; bad++;
      $display("FAIL send_timeout a=%h ack=%b want 1", a, input_a_ack);
    end
    @(posedge clk);
    #1 input_a_stb = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic [31:0] z);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!output_z_stb && lat < 200);
    if (!output_z_stb) begin
      total++; bad++;
      $display("FAIL result_timeout stb=%b want 1", output_z_stb);
    end
    z = output_z;
  endtask

  task automatic ack_result();
    @(negedge clk);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] a, input string tag);
    int lat;
    logic [31:0] z;
    send(a);
    wait_result(lat, z);
    total++;
    if (z !== ref_conv(a)) begin
      bad++;
      $display("FAIL %s_val a=%h got=%h want=%h", tag, a, z, ref_conv(a));
    end
    total++;
    if (lat !== ref_lat(a)) begin
      bad++;
      $display("FAIL %s_lat a=%h got=%0d want=%0d", tag, a, lat, ref_lat(a));
    end
    ack_result();
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({input_a_ack, output_z_stb, output_z} !== 34'd0) begin
      bad++;
      $display("FAIL reset_vals got=%b/%b/%h want 0/0/0",
               input_a_ack, output_z_stb, output_z);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (input_a_ack !== 1'b1) begin
      bad++;
      $display("FAIL reset_ack_rise got=%b want 1", input_a_ack);
    end
  endtask

  task automatic test_directed();
    logic [31:0] v [10];
    v = '{32'h3F80_0000, 32'hC020_0000, 32'h3F40_0000, 32'h0000_0001,
          32'h4F32_D05E, 32'h7FC0_0000, 32'hCF00_0000, 32'h4E80_0000,
          32'hFF80_0000, 32'h7F80_0000};
    foreach (v[i]) run_one(v[i], "directed");
  endtask

  task automatic test_random();
    logic [31:0] f;
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 4) f = $urandom;
      else f = {1'($urandom), 8'($urandom_range(120, 160)), 23'($urandom)};
      run_one(f, "random");
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int errs = 0;
    logic [31:0] z;
    send(32'hC2F6_0000);
    wait_result(lat, z);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (output_z_stb !== 1'b1 || output_z !== z || input_a_ack !== 1'b0)
        errs++;
    end
    total++;
    if (errs != 0 || z !== 32'hFFFF_FF85) begin
      bad++;
      $display("FAIL backpressure errs=%0d z=%h want 0 and ffffff85", errs, z);
    end
    ack_result();
    total++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0) begin
      bad++;
      $display("FAIL ack_gap ack=%b stb=%b want 0/0", input_a_ack, output_z_stb);
    end
    @(posedge clk);
    #1;
    total++;
    if (input_a_ack !== 1'b1) begin
      bad++;
      $display("FAIL ack_return got=%b want 1", input_a_ack);
    end
    run_one(32'h4640_E400, "after_bp");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    send(32'h4B00_0000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({input_a_ack, output_z_stb, output_z} !== 34'd0) begin
      bad++;
      $display("FAIL midreset_vals got=%b/%b/%h want 0/0/0",
               input_a_ack, output_z_stb, output_z);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (output_z_stb) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL stale_result got=%0d stb cycles want 0", seen);
    end
    run_one(32'h42F6_0000, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
